// File: rtl/program_loader.sv
// Boot loader: packs a byte stream into 32-bit little-endian words and writes them to program memory.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_add,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int BYTES = WIDTH / 8;
  localparam int IDX_W = $clog2(BYTES);
  localparam int CNT_W = ADD_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LOAD, S_WRITE, S_CHK, S_FIN, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [ADD_WIDTH-1:0] mem_add_q, mem_add_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     left_q, left_d;
  logic                 accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_add_q <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      left_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mem_add_q <= mem_add_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      left_q    <= left_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Outputs decode straight from the state register, so ready never depends on valid.
  assign byte_ready = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CHK);
  assign accept     = byte_ready && byte_valid;
  assign mem_wen    = (state_q == S_WRITE);
  assign mem_add    = mem_add_q;
  assign mem_wdata  = wdata_q;
  assign busy       = byte_ready || (state_q == S_WRITE);
  assign done       = (state_q == S_FIN);
  assign cpu_rst    = (state_q != S_FIN);
`ifdef LOADER_CHECKSUM_EN
  assign err        = (state_q == S_ERR);
`else
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mem_add_d = mem_add_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    left_d    = left_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE, S_FIN, S_ERR: begin
        if (start) begin
          state_d   = S_LEN;
          mem_add_d = '0;
          idx_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          // A length byte of zero means a full-depth image.
          left_d  = (byte_in == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(byte_in);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wdata_d[{idx_q, 3'b000} +: 8] = byte_in;
          idx_d = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
`endif
          if (idx_q == IDX_W'(BYTES - 1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_add_d = mem_add_q + 1'b1;
        left_d    = left_q - 1'b1;
        if (left_q == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_FIN;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (byte_in == csum_q) ? S_FIN : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_wen, cpu_rst, busy, done, err;
  logic [7:0]  mem_add;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_add_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_words[256];
  int          rdy_viol = 0;

  program_loader #(.WIDTH(32), .ADD_WIDTH(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_wen(mem_wen), .mem_add(mem_add), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory-side observer: logs every write strobe seen in a cycle.
  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      wr_add_q.push_back(mem_add);
      wr_data_q.push_back(mem_wdata);
      if (byte_ready !== 1'b0) rdy_viol++;
    end
  end

  // Reference: word i of the image must land at address i, nothing else.
  function automatic int bad_writes(int n);
    int bad;
    bad = (wr_add_q.size() != n) ? 1 : 0;
    for (int i = 0; i < wr_add_q.size() && i < n; i++)
      if (wr_add_q[i] !== 8'(i) || wr_data_q[i] !== exp_words[i]) bad++;
    return bad;
  endfunction

  function automatic logic [7:0] image_csum(int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) x = x ^ 8'((exp_words[i] >> (8 * k)) & 32'hFF);
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int  g;
    logic r;
    bit  got;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    byte_valid = 1'b0;
    repeat (g) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      r = byte_ready;
      @(negedge clk);
      if (r) got = 1'b1;
    end
    byte_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL byte_timeout: byte %02h never accepted, required acceptance within 50 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int k = 0; k < 4; k++) send_byte(8'((w >> (8 * k)) & 32'hFF), gapmax);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bool_wait: for (int n = 0; n < 20; n++) begin
      if (done === 1'b1 || err === 1'b1) break;
      @(negedge clk);
    end
    if (!(done === 1'b1 || err === 1'b1)) begin
      checks++; errors++;
      $display("FAIL %s_end_timeout: done=%b err=%b, required done or err within 20 cycles", name, done, err);
    end
  endtask

  task automatic run_image(input int n, input bit good_csum, input int gapmax);
    wr_add_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'(n), gapmax);
    for (int i = 0; i < n; i++) send_word(exp_words[i], gapmax);
`ifdef LOADER_CHECKSUM_EN
    send_byte(good_csum ? image_csum(n) : (image_csum(n) ^ 8'h01), gapmax);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b1; byte_in = 8'hA5;
    #1;
    checks++;
    if ({byte_ready, mem_wen, cpu_rst, busy, done, err} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_ctrl: rdy,wen,cpu_rst,busy,done,err=%b required 001000",
               {byte_ready, mem_wen, cpu_rst, busy, done, err});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_add !== 8'h00 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: add=%h wdata=%h required 00 00000000", mem_add, mem_wdata);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_ready: byte_ready=%b busy=%b required 0 0", byte_ready, busy);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_basic();
    exp_words[0] = 32'h00500013;
    exp_words[1] = 32'h00100093;
    wr_add_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_word(32'h00500013, 0);
    send_word(32'h00100093, 0);
    checks++;
    if (mem_wen !== 1'b1 || mem_add !== 8'h01 || mem_wdata !== 32'h00100093) begin
      errors++;
      $display("FAIL basic_write_latency: wen=%b add=%h data=%h required 1 01 00100093", mem_wen, mem_add, mem_wdata);
    end
    @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    send_byte(image_csum(2), 0);
`endif
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b cpu_rst=%b busy=%b wen=%b required 1 0 0 0", done, cpu_rst, busy, mem_wen);
    end
    checks++;
    if (bad_writes(2) !== 0) begin
      errors++;
      $display("FAIL basic_writes: %0d writes with %0d bad, required 2 writes 00500013@0 00100093@1",
               wr_add_q.size(), bad_writes(2));
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) exp_words[i] = $urandom;
      run_image(n, 1'b1, 2);
      wait_end("random");
      checks++;
      if (bad_writes(n) !== 0 || done !== 1'b1 || cpu_rst !== 1'b0 || mem_add !== 8'(n)) begin
        errors++;
        $display("FAIL random_load: n=%0d writes=%0d bad=%0d done=%b cpu_rst=%b add=%h required %0d writes 0 bad 1 0 add=%h",
                 n, wr_add_q.size(), bad_writes(n), done, cpu_rst, mem_add, n, 8'(n));
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    for (int i = 0; i < 2; i++) exp_words[i] = $urandom;
    run_image(2, 1'b0, 1);
    wait_end("bad_csum");
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum: err=%b done=%b cpu_rst=%b busy=%b required 1 0 1 0", err, done, cpu_rst, busy);
    end
  endtask
`endif

  task automatic test_full_depth();
    for (int i = 0; i < 256; i++) exp_words[i] = $urandom;
    run_image(256, 1'b1, 0);
    wait_end("full");
    repeat (4) @(negedge clk);
    checks++;
    if (bad_writes(256) !== 0) begin
      errors++;
      $display("FAIL full_writes: %0d writes with %0d bad, required 256 writes to 0..255", wr_add_q.size(), bad_writes(256));
    end
    checks++;
    if (done !== 1'b1 || mem_add !== 8'h00 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL full_done: done=%b add=%h cpu_rst=%b required 1 00 0", done, mem_add, cpu_rst);
    end
  endtask

  task automatic test_backpressure();
    exp_words[0] = 32'hDEADBEEF;
    run_image(1, 1'b1, 4);
    wait_end("bp");
    checks++;
    if (bad_writes(1) !== 0) begin
      errors++;
      $display("FAIL bp_write: %0d writes first=%h required 1 write deadbeef@0",
               wr_add_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0);
    end
    checks++;
    if (rdy_viol !== 0) begin
      errors++;
      $display("FAIL bp_ready_in_write: %0d write cycles with byte_ready=1, required 0", rdy_viol);
    end
  endtask

  task automatic test_reset_midload();
    exp_words[0] = $urandom;
    exp_words[1] = $urandom;
    pulse_start();
    send_byte(8'h02, 0);
    send_word(exp_words[0], 0);
    send_byte(8'(exp_words[1] & 32'hFF), 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_wen !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL midload_reset: wen=%b cpu_rst=%b busy=%b rdy=%b wdata=%h required 0 1 0 0 00000000",
               mem_wen, cpu_rst, busy, byte_ready, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_stays_idle: rdy=%b busy=%b required 0 0", byte_ready, busy);
    end
    for (int i = 0; i < 3; i++) exp_words[i] = $urandom;
    run_image(3, 1'b1, 1);
    wait_end("midload");
    checks++;
    if (bad_writes(3) !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL midload_reload: writes=%0d bad=%0d done=%b required 3 0 1", wr_add_q.size(), bad_writes(3), done);
    end
  endtask

  task automatic test_reload();
    pulse_start();
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || mem_add !== 8'h00) begin
      errors++;
      $display("FAIL reload_start: cpu_rst=%b done=%b busy=%b add=%h required 1 0 1 00", cpu_rst, done, busy, mem_add);
    end
    exp_words[0] = $urandom;
    exp_words[1] = $urandom;
    wr_add_q.delete();
    wr_data_q.delete();
    send_byte(8'h02, 0);
    send_byte(8'(exp_words[0] & 32'hFF), 0);
    send_byte(8'((exp_words[0] >> 8) & 32'hFF), 0);
    pulse_start();
    send_byte(8'((exp_words[0] >> 16) & 32'hFF), 0);
    send_byte(8'((exp_words[0] >> 24) & 32'hFF), 0);
    send_word(exp_words[1], 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(image_csum(2), 0);
`endif
    wait_end("reload");
    checks++;
    if (bad_writes(2) !== 0 || done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL reload_ignore_start: writes=%0d bad=%0d done=%b cpu_rst=%b required 2 0 1 0",
               wr_add_q.size(), bad_writes(2), done, cpu_rst);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_full_depth();
    test_backpressure();
    test_reset_midload();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
